// File: rtl/alu_driver.sv
`default_nettype none
// ============================================================================
// alu_driver : sequences one host request into an operand-serial ALU and
//              returns the result (or a timeout abort) to the host.
// Rev 1.0
// ============================================================================
module alu_driver #(
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_inbus,
  input  logic [15:0] alu_outbus,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout,
  output logic [7:0]  op_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [3:0]  c_hold_last    = 4'(HOLD - 1);
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        req_ready_q, req_ready_d;
  logic        alu_start_q, alu_start_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [7:0]  alu_inbus_q, alu_inbus_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [7:0]  op_count_q, op_count_d;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    op_count_d    = op_count_q;

    case (state_q)
      S_IDLE: begin
        // req_ready_q is low for the first cycle after reset, so gate on it
        if (req_valid && req_ready_q) begin
          op_d       = req_op;
          a_d        = req_a;
          b_d        = req_b;
          hold_cnt_d = 4'd0;
          state_d    = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (hold_cnt_q == c_hold_last) begin
          hold_cnt_d = 4'd0;
          state_d    = S_LOAD_B;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      S_LOAD_B: begin
        if (hold_cnt_q == c_hold_last) begin
          hold_cnt_d = 4'd0;
          wait_cnt_d = 16'd0;
          state_d    = S_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        // done on the last counted cycle takes priority over the timeout
        if (alu_done) begin
          rsp_result_d  = alu_outbus;
          rsp_timeout_d = 1'b0;
          op_count_d    = op_count_q + 8'd1;
          state_d       = S_RESP;
        end else if (wait_cnt_q == c_timeout_last) begin
          rsp_result_d  = 16'd0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered images of the state being entered
    req_ready_d = (state_d == S_IDLE);
    alu_start_d = (state_d == S_LOAD_A);
    rsp_valid_d = (state_d == S_RESP);
    alu_op_d    = 2'd0;
    alu_inbus_d = 8'd0;
    if (state_d == S_LOAD_A) begin
      alu_op_d    = op_d;
      alu_inbus_d = a_d;
    end else if (state_d == S_LOAD_B || state_d == S_WAIT) begin
      alu_op_d    = op_d;
      alu_inbus_d = b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= 4'd0;
      wait_cnt_q    <= 16'd0;
      op_q          <= 2'd0;
      a_q           <= 8'd0;
      b_q           <= 8'd0;
      req_ready_q   <= 1'b0;
      alu_start_q   <= 1'b0;
      alu_op_q      <= 2'd0;
      alu_inbus_q   <= 8'd0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 16'd0;
      rsp_timeout_q <= 1'b0;
      op_count_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      req_ready_q   <= req_ready_d;
      alu_start_q   <= alu_start_d;
      alu_op_q      <= alu_op_d;
      alu_inbus_q   <= alu_inbus_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      op_count_q    <= op_count_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign alu_start   = alu_start_q;
  assign alu_op      = alu_op_q;
  assign alu_inbus   = alu_inbus_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign op_count    = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_driver.sv
`default_nettype none
// ============================================================================
// tb_alu_driver : directed scoreboard bench for alu_driver.
// Rev 1.0
// ============================================================================
module tb_alu_driver;

  localparam int HOLD    = 2;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [7:0]  alu_inbus;
  logic [15:0] alu_outbus;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_timeout;
  logic [7:0]  op_count;

  typedef struct {
    logic [15:0] result;
    logic        timeout;
    logic [7:0]  count;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_cnt;
  int         checks   = 0;
  int         failures = 0;

  alu_driver #(.HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_inbus  (alu_inbus),
    .alu_outbus (alu_outbus),
    .alu_done   (alu_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_timeout(rsp_timeout),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_inbus", 32'(alu_inbus), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    chk_reset_outputs();
    rst = 1'b1;
    exp_cnt = 8'd0;
    tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);
  endtask

  // done_at: WAIT cycle index where alu_done is pulsed (<0 means never)
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int done_at, input logic [15:0] outv,
                        input bit early, input int bp);
    exp_t e;
    int   exp_wait;
    int   n;
    if (done_at >= 0 && done_at < TIMEOUT) begin
      exp_cnt  = exp_cnt + 8'd1;
      e        = '{result: outv, timeout: 1'b0, count: exp_cnt};
      exp_wait = done_at + 1;
    end else begin
      e        = '{result: 16'd0, timeout: 1'b1, count: exp_cnt};
      exp_wait = TIMEOUT;
    end
    sb.push_back(e);

    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    req_op    = ~op;
    req_a     = ~a;
    req_b     = ~b;

    for (int i = 0; i < HOLD; i++) begin
      chk("loada_start", 32'(alu_start), 32'd1);
      chk("loada_inbus", 32'(alu_inbus), 32'(a));
      chk("loada_op", 32'(alu_op), 32'(op));
      chk("loada_req_ready", 32'(req_ready), 32'd0);
      chk("loada_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
    end
    for (int i = 0; i < HOLD; i++) begin
      if (early && i == 0) begin
        alu_done   = 1'b1;
        alu_outbus = 16'hBEEF;
      end
      chk("loadb_start", 32'(alu_start), 32'd0);
      chk("loadb_inbus", 32'(alu_inbus), 32'(b));
      chk("loadb_op", 32'(alu_op), 32'(op));
      tick();
      alu_done = 1'b0;
    end

    n = 0;
    while (!rsp_valid && n < TIMEOUT + 4) begin
      chk("wait_inbus", 32'(alu_inbus), 32'(b));
      chk("wait_op", 32'(alu_op), 32'(op));
      alu_done   = (n == done_at);
      alu_outbus = alu_done ? outv : 16'h1234;
      tick();
      n++;
    end
    alu_done = 1'b0;
    chk("wait_cycles", 32'(n), 32'(exp_wait));
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end
    chk("rsp_result", 32'(rsp_result), 32'(e.result));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
    chk("op_count", 32'(op_count), 32'(e.count));
    chk("resp_alu_start", 32'(alu_start), 32'd0);
    chk("resp_alu_op", 32'(alu_op), 32'd0);
    chk("resp_alu_inbus", 32'(alu_inbus), 32'd0);
    chk("resp_req_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", 32'(rsp_result), 32'(e.result));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_a      = 8'd0;
    req_b      = 8'd0;
    alu_outbus = 16'd0;
    alu_done   = 1'b0;
    rsp_ready  = 1'b0;
    exp_cnt    = 8'd0;

    do_reset();

    // Add 5+3 with minimal latency
    run_op(2'b10, 8'd5, 8'd3, 0, 16'd8, 1'b0, 0);
    // Early done during LOAD_B ignored, real done 5 cycles into WAIT
    run_op(2'b10, 8'd14, 8'd52, 5, 16'd66, 1'b1, 0);
    // Timeout abort
    run_op(2'b01, 8'hAA, 8'h55, -1, 16'd0, 1'b0, 0);
    // Done on the final counted cycle beats timeout
    run_op(2'b11, 8'h0F, 8'hF0, TIMEOUT - 1, 16'hC0DE, 1'b0, 0);
    // Response backpressure
    run_op(2'b00, 8'd7, 8'd9, 2, 16'h0077, 1'b0, 10);

    // Reset while waiting on the ALU
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_a     = 8'd40;
    req_b     = 8'd41;
    tick();
    req_valid = 1'b0;
    repeat (2 * HOLD + 2) tick();
    chk("midwait_op", 32'(alu_op), 32'd1);
    rst = 1'b0;
    tick();
    chk_reset_outputs();
    rst     = 1'b1;
    exp_cnt = 8'd0;
    tick();
    chk("midwait_req_ready", 32'(req_ready), 32'd1);
    run_op(2'b00, 8'd1, 8'd2, 0, 16'd3, 1'b0, 0);

    // op_count wraps after 256 completions
    for (int i = 0; i < 255; i++) begin
      run_op(2'(i), 8'(i), 8'(i + 1), i % 3, 16'(i * 7), 1'b0, 0);
    end
    chk("wrap_op_count", 32'(op_count), 32'd0);
    chk("sb_final", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter HOLD, default 2: cycles each operand is presented on alu_inbus (range 1..15).
REQ-002 Parameter TIMEOUT, default 64: max cycles in WAIT before abort (range 1..65535).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  driver accepts request this cycle.
REQ-007 req_op  input  2  ALU opcode for request.
REQ-008 req_a  input  8  first operand.
REQ-009 req_b  input  8  second operand.
REQ-010 alu_start  output  1  start strobe to ALU.
REQ-011 alu_op  output  2  opcode to ALU.
REQ-012 alu_inbus  output  8  operand bus to ALU.
REQ-013 alu_outbus  input  16  ALU result bus.
REQ-014 alu_done  input  1  ALU result valid on alu_outbus.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  host consumes response.
REQ-017 rsp_result  output  16  captured result.
REQ-018 rsp_timeout  output  1  response is a timeout abort.
REQ-019 op_count  output  8  completed (non-timeout) operations, wraps 255->0.

Function
REQ-020 FSM states SHALL be IDLE, LOAD_A, LOAD_B, WAIT, RESP; all outputs registered.
REQ-021 IDLE: req_ready=1; req_valid=1 captures req_op/req_a/req_b, next state LOAD_A; req_ready=0 in every other state.
REQ-022 LOAD_A: alu_start=1, alu_inbus=captured a, exactly HOLD cycles, then LOAD_B.
REQ-023 LOAD_B: alu_start=0, alu_inbus=captured b, exactly HOLD cycles, then WAIT.
REQ-024 alu_op SHALL equal captured op from first LOAD_A cycle through last WAIT cycle; alu_inbus SHALL hold b through WAIT.
REQ-025 In IDLE and RESP: alu_start=0, alu_op=0, alu_inbus=0.
REQ-026 alu_done SHALL be ignored outside WAIT.
REQ-027 WAIT: alu_done=1 captures alu_outbus into rsp_result, rsp_timeout=0, op_count+1, next RESP.
REQ-028 WAIT: 16-bit counter from 0 on entry; if TIMEOUT cycles elapse without alu_done, rsp_result=0, rsp_timeout=1, next RESP; alu_done on the final counted cycle wins over timeout.
REQ-029 RESP: rsp_valid=1, rsp_result/rsp_timeout stable until rsp_ready=1; that cycle returns to IDLE, rsp_valid drops next cycle.
REQ-030 Minimum request-to-rsp_valid latency SHALL be 2*HOLD+2 cycles (alu_done high on first WAIT cycle).
REQ-031 New request SHALL be accepted no earlier than the cycle after RESP->IDLE; no back-to-back acceptance while busy.
REQ-032 op_count SHALL not change on timeout.

Reset
REQ-033 rst=0 at a rising edge SHALL force IDLE from any state, including mid-LOAD/WAIT/RESP, discarding any in-flight request.
REQ-034 Reset values: req_ready=0 during reset then 1 in IDLE, alu_start=0, alu_op=0, alu_inbus=0, rsp_valid=0, rsp_result=0, rsp_timeout=0, op_count=0, counters=0.

Verification
REQ-035 Add: req op=2'b10, a=5, b=3; alu_start=1 with inbus=5 for 2 cycles, inbus=3 for 2 cycles; alu_done with outbus=8 -> rsp_result=16'd8, rsp_timeout=0, op_count=1.
REQ-036 Operands a=14, b=52, op=2'b10, alu_done asserted during LOAD_B and again 5 cycles into WAIT with outbus=66 -> early done ignored, rsp_result=16'd66.
REQ-037 Timeout: alu_done never asserted, TIMEOUT=64 -> rsp_valid after exactly 64 WAIT cycles, rsp_result=0, rsp_timeout=1, op_count unchanged.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_result stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle, req_ready=1.
REQ-039 Reset mid-WAIT: rst=0 one cycle -> all outputs at reset values, subsequent request (a=1, b=2, done outbus=3) completes with rsp_result=3.
REQ-040 Wrap: 256 completed ops -> op_count returns to 0.
